mpp_hover_scheduler: RTL and testbench

MPP_HOVER_SCHEDULER -- requirements
Module: mpp_hover_scheduler

---
 rtl/mpp_hover_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_mpp_hover_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpp_hover_scheduler.sv
// -----------------------------------------------------------------------------
// mpp_hover_scheduler
//
// Sequences the enable of an MPP ring-hover generator as a run made of an
// optional lead-in delay followed by a number of bursts separated by gaps.
// While the enable is high, the monitored generator output is peak-tracked.
//
// Ports
//   clk              : single clock, everything changes on the rising edge
//   rst              : synchronous active-high reset
//   start            : run request, only honoured while idle
//   abort            : terminates an active run (lead, burst or gap)
//   cfg_lead_len     : idle cycles between start and the first burst (0 = none)
//   cfg_burst_len    : enable-high cycles per burst (0 treated as 1)
//   cfg_gap_len      : enable-low cycles between bursts (0 treated as 1)
//   cfg_repeat       : bursts per run (0 treated as 1)
//   MPPsignal_in     : monitored generator output, unsigned
//   enablePortTypeHF : registered generator enable, high exactly in BURST
//   busy             : high in every state except IDLE
//   done             : one-cycle pulse on normal completion
//   aborted          : one-cycle pulse when a run is aborted
//   burst_cnt        : bursts completed in the current or last run (saturating)
//   peak_out         : largest MPPsignal_in seen while the enable was high
// -----------------------------------------------------------------------------
module mpp_hover_scheduler #(
   parameter int CNT_W = 16,
   parameter int SIG_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_lead_len,
   input  logic [CNT_W-1:0] cfg_burst_len,
   input  logic [CNT_W-1:0] cfg_gap_len,
   input  logic [7:0]       cfg_repeat,
   input  logic [SIG_W-1:0] MPPsignal_in,
   output logic             enablePortTypeHF,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [7:0]       burst_cnt,
   output logic [SIG_W-1:0] peak_out
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEAD  = 3'd1,
      ST_BURST = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;          // down-counter for the current phase, 0 = last cycle
   logic [CNT_W-1:0] burst_len_r;    // latched, already normalised to >= 1
   logic [CNT_W-1:0] gap_len_r;      // latched, already normalised to >= 1
   logic [7:0]       rep_left_r;     // bursts still to run, including the current one

   logic [CNT_W-1:0] burst_eff_s;
   logic [CNT_W-1:0] gap_eff_s;
   logic [7:0]       rep_eff_s;
   logic             lead_zero_s;
   logic             cnt_zero_s;
   logic             last_burst_s;
   logic             abort_hit_s;

   // A zero length would otherwise wrap the down-counter; run it as one cycle.
   function automatic logic [CNT_W-1:0] len_at_least_one(input logic [CNT_W-1:0] len);
      if (len == CNT_ZERO) begin
         return CNT_ONE;
      end else begin
         return len;
      end
   endfunction

   // Same normalisation for the 8-bit repeat count.
   function automatic logic [7:0] rep_at_least_one(input logic [7:0] rep);
      if (rep == 8'd0) begin
         return 8'd1;
      end else begin
         return rep;
      end
   endfunction

   // Saturating increment for the completed-burst counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] val);
      if (val == 8'hFF) begin
         return 8'hFF;
      end else begin
         return val + 8'd1;
      end
   endfunction

   // Normalised configuration and phase-end decode.
   always_comb begin
      burst_eff_s  = len_at_least_one(cfg_burst_len);
      gap_eff_s    = len_at_least_one(cfg_gap_len);
      rep_eff_s    = rep_at_least_one(cfg_repeat);
      lead_zero_s  = (cfg_lead_len == CNT_ZERO);
      cnt_zero_s   = (cnt_r == CNT_ZERO);
      last_burst_s = (rep_left_r <= 8'd1);
      abort_hit_s  = 1'b0;
      case (state_r)
         ST_LEAD, ST_BURST, ST_GAP: abort_hit_s = abort;
         ST_IDLE, ST_DONE:          abort_hit_s = 1'b0;
         default:                   abort_hit_s = 1'b0;
      endcase
   end

   // Run sequencer: state, phase counter, latched configuration and all outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r          <= ST_IDLE;
         cnt_r            <= CNT_ZERO;
         burst_len_r      <= CNT_ZERO;
         gap_len_r        <= CNT_ZERO;
         rep_left_r       <= 8'd0;
         enablePortTypeHF <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         aborted          <= 1'b0;
         burst_cnt        <= 8'd0;
         peak_out         <= {SIG_W{1'b0}};
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;

         // Peak is sampled on every enable-high cycle except the one that is
         // being aborted, so an abort leaves peak_out exactly as it was.
         if (enablePortTypeHF && !abort_hit_s && (MPPsignal_in > peak_out)) begin
            peak_out <= MPPsignal_in;
         end

         if (abort_hit_s) begin
            // Abort wins over any phase end, including the last burst cycle.
            state_r          <= ST_IDLE;
            cnt_r            <= CNT_ZERO;
            enablePortTypeHF <= 1'b0;
            busy             <= 1'b0;
            aborted          <= 1'b1;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (start) begin
                     // The lead length is consumed here by loading the counter,
                     // so only the later-used lengths need their own latch.
                     burst_len_r <= burst_eff_s;
                     gap_len_r   <= gap_eff_s;
                     rep_left_r  <= rep_eff_s;
                     burst_cnt   <= 8'd0;
                     peak_out    <= {SIG_W{1'b0}};
                     busy        <= 1'b1;
                     if (lead_zero_s) begin
                        state_r          <= ST_BURST;
                        cnt_r            <= burst_eff_s - CNT_ONE;
                        enablePortTypeHF <= 1'b1;
                     end else begin
                        state_r <= ST_LEAD;
                        cnt_r   <= cfg_lead_len - CNT_ONE;
                     end
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end

               ST_LEAD: begin
                  if (cnt_zero_s) begin
                     state_r          <= ST_BURST;
                     cnt_r            <= burst_len_r - CNT_ONE;
                     enablePortTypeHF <= 1'b1;
                  end else begin
                     cnt_r <= cnt_r - CNT_ONE;
                  end
               end

               ST_BURST: begin
                  if (cnt_zero_s) begin
                     burst_cnt        <= sat_inc8(burst_cnt);
                     enablePortTypeHF <= 1'b0;
                     if (last_burst_s) begin
                        state_r    <= ST_DONE;
                        cnt_r      <= CNT_ZERO;
                        rep_left_r <= 8'd0;
                        done       <= 1'b1;
                     end else begin
                        state_r    <= ST_GAP;
                        cnt_r      <= gap_len_r - CNT_ONE;
                        rep_left_r <= rep_left_r - 8'd1;
                     end
                  end else begin
                     cnt_r <= cnt_r - CNT_ONE;
                  end
               end

               ST_GAP: begin
                  if (cnt_zero_s) begin
                     state_r          <= ST_BURST;
                     cnt_r            <= burst_len_r - CNT_ONE;
                     enablePortTypeHF <= 1'b1;
                  end else begin
                     cnt_r <= cnt_r - CNT_ONE;
                  end
               end

               ST_DONE: begin
                  // Single completion cycle; start is ignored here as busy is high.
                  state_r <= ST_IDLE;
                  busy    <= 1'b0;
               end

               default: begin
                  state_r          <= ST_IDLE;
                  cnt_r            <= CNT_ZERO;
                  enablePortTypeHF <= 1'b0;
                  busy             <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mpp_hover_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mpp_hover_scheduler
//
// Directed bench for mpp_hover_scheduler. Expected enable edges and done /
// aborted pulses are queued with their cycle offset from the accepting edge
// before each run; a per-cycle monitor pops and compares them as the DUT
// produces them. Offset 1 is the cycle right after the edge that took start.
// -----------------------------------------------------------------------------
module tb_mpp_hover_scheduler;

   localparam int EV_RISE  = 1;
   localparam int EV_FALL  = 2;
   localparam int EV_DONE  = 3;
   localparam int EV_ABORT = 4;

   typedef struct {
      int kind;
      int off;
   } ev_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [15:0] cfg_lead_len;
   logic [15:0] cfg_burst_len;
   logic [15:0] cfg_gap_len;
   logic [7:0]  cfg_repeat;
   logic [23:0] sig;
   logic        en;
   logic        busy;
   logic        done;
   logic        aborted;
   logic [7:0]  burst_cnt;
   logic [23:0] peak;

   ev_t sb[$];
   int  total;
   int  bad;
   int  cyc;
   int  e0;
   logic prev_en;

   mpp_hover_scheduler #(.CNT_W(16), .SIG_W(24)) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .abort            (abort),
      .cfg_lead_len     (cfg_lead_len),
      .cfg_burst_len    (cfg_burst_len),
      .cfg_gap_len      (cfg_gap_len),
      .cfg_repeat       (cfg_repeat),
      .MPPsignal_in     (sig),
      .enablePortTypeHF (en),
      .busy             (busy),
      .done             (done),
      .aborted          (aborted),
      .burst_cnt        (burst_cnt),
      .peak_out         (peak)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int off();
      return cyc - e0 + 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_ev(input int kind, input int at);
      ev_t e;
      e.kind = kind;
      e.off  = at;
      sb.push_back(e);
   endtask

   task automatic expect_ev(input int kind);
      ev_t e;
      if (sb.size() == 0) begin
         chk("sb_unexpected_event", kind, 0);
      end else begin
         e = sb.pop_front();
         chk("ev_kind", kind, e.kind);
         chk("ev_time", off(), e.off);
      end
   endtask

   // Advance one cycle and check any enable edge or pulse against the queue.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (prev_en === 1'b1 && en === 1'b0) expect_ev(EV_FALL);
      if (done === 1'b1) expect_ev(EV_DONE);
      if (aborted === 1'b1) expect_ev(EV_ABORT);
      if (prev_en !== 1'b1 && en === 1'b1) expect_ev(EV_RISE);
      prev_en = en;
   endtask

   task automatic start_run(input logic [15:0] lead, input logic [15:0] burst,
                            input logic [15:0] gap, input logic [7:0] rep);
      cfg_lead_len  = lead;
      cfg_burst_len = burst;
      cfg_gap_len   = gap;
      cfg_repeat    = rep;
      start         = 1'b1;
      e0            = cyc + 1;
      tick();
      start         = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk(tag, ok, 1'b1);
   endtask

   initial begin
      logic fin;
      total = 0; bad = 0; cyc = 0; e0 = 0; prev_en = 1'b0;
      rst = 1'b1; start = 1'b0; abort = 1'b0; sig = 24'h0;
      cfg_lead_len = 16'd0; cfg_burst_len = 16'd0; cfg_gap_len = 16'd0; cfg_repeat = 8'd0;
      tick();
      tick();
      chk("rst_en", en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_aborted", aborted, 1'b0);
      chk("rst_burst_cnt", burst_cnt, 8'd0);
      chk("rst_peak", peak, 24'h0);
      rst = 1'b0;
      tick();

      // Single long burst after a lead; cfg changes and a start while busy are ignored.
      sig = 24'h123456;
      push_ev(EV_RISE, 3540);
      push_ev(EV_FALL, 4010);
      push_ev(EV_DONE, 4010);
      start_run(16'd3539, 16'd470, 16'd7, 8'd1);
      chk("t1_busy", busy, 1'b1);
      cfg_lead_len = 16'd5; cfg_burst_len = 16'd3; cfg_gap_len = 16'd1; cfg_repeat = 8'd9;
      repeat (50) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle(5000, "t1_timeout");
      repeat (3) tick();
      chk("t1_sb_drained", sb.size(), 0);
      chk("t1_burst_cnt", burst_cnt, 8'd1);
      chk("t1_peak", peak, 24'h123456);

      // Three bursts with gaps, no lead, and peak tracking only inside bursts.
      sig = 24'h000100;
      push_ev(EV_RISE, 1);  push_ev(EV_FALL, 11);
      push_ev(EV_RISE, 16); push_ev(EV_FALL, 26);
      push_ev(EV_RISE, 31); push_ev(EV_FALL, 41); push_ev(EV_DONE, 41);
      start_run(16'd0, 16'd10, 16'd5, 8'd3);
      fin = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (busy === 1'b0) begin
            fin = 1'b1;
            break;
         end
         if (off() == 3)  chk("t2_peak_cleared", peak, 24'h000100);
         if (off() == 5)  sig = 24'hABCDEF;
         if (off() == 11) sig = 24'hFFFFFF;
         if (off() == 13) chk("t2_peak_gap", peak, 24'hABCDEF);
         if (off() == 13) chk("t2_cnt_mid1", burst_cnt, 8'd1);
         if (off() == 15) sig = 24'h000200;
         if (off() == 27) chk("t2_cnt_mid2", burst_cnt, 8'd2);
         tick();
      end
      chk("t2_timeout", fin, 1'b1);
      repeat (3) tick();
      chk("t2_sb_drained", sb.size(), 0);
      chk("t2_burst_cnt", burst_cnt, 8'd3);
      chk("t2_peak", peak, 24'hABCDEF);

      // All-zero configuration gives one 1-cycle pulse; abort in DONE is ignored.
      sig = 24'h000042;
      push_ev(EV_RISE, 1); push_ev(EV_FALL, 2); push_ev(EV_DONE, 2);
      start_run(16'd0, 16'd0, 16'd0, 8'd0);
      fin = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (busy === 1'b0) begin
            fin = 1'b1;
            break;
         end
         abort = (off() == 2);
         tick();
      end
      abort = 1'b0;
      chk("t3_timeout", fin, 1'b1);
      repeat (3) tick();
      chk("t3_sb_drained", sb.size(), 0);
      chk("t3_burst_cnt", burst_cnt, 8'd1);
      chk("t3_peak", peak, 24'h000042);

      // Abort in the middle of the second burst.
      sig = 24'h000777;
      push_ev(EV_RISE, 3);  push_ev(EV_FALL, 11);
      push_ev(EV_RISE, 15); push_ev(EV_FALL, 19); push_ev(EV_ABORT, 19);
      start_run(16'd2, 16'd8, 16'd4, 8'd3);
      fin = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (busy === 1'b0) begin
            fin = 1'b1;
            break;
         end
         abort = (off() == 18);
         tick();
      end
      abort = 1'b0;
      chk("t4_timeout", fin, 1'b1);
      chk("t4_abort_at", off(), 19);
      repeat (3) tick();
      chk("t4_sb_drained", sb.size(), 0);
      chk("t4_burst_cnt", burst_cnt, 8'd1);
      chk("t4_peak", peak, 24'h000777);

      // Start and abort together while idle: the run starts.
      sig = 24'h000010;
      push_ev(EV_RISE, 1); push_ev(EV_FALL, 3); push_ev(EV_DONE, 3);
      abort = 1'b1;
      start_run(16'd0, 16'd2, 16'd0, 8'd1);
      abort = 1'b0;
      chk("t5_busy", busy, 1'b1);
      wait_idle(20, "t5_timeout");
      repeat (3) tick();
      chk("t5_sb_drained", sb.size(), 0);
      chk("t5_burst_cnt", burst_cnt, 8'd1);
      chk("t5_peak", peak, 24'h000010);

      // Reset in the middle of a burst clears everything on that edge.
      sig = 24'h000555;
      push_ev(EV_RISE, 2); push_ev(EV_FALL, 6);
      start_run(16'd1, 16'd20, 16'd3, 8'd1);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      chk("t6_en", en, 1'b0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_done", done, 1'b0);
      chk("t6_aborted", aborted, 1'b0);
      chk("t6_burst_cnt", burst_cnt, 8'd0);
      chk("t6_peak", peak, 24'h0);
      rst = 1'b0;
      repeat (3) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      repeat (3) tick();
      chk("t6_idle_busy", busy, 1'b0);
      chk("t6_sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
